// File: rtl/dcache_pkg.sv
// Shared types and default geometry for the direct-mapped write-back L1 data cache.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, default ADDR_W/NUM_LINES/LINE_BYTES, derived field widths, tag/index/line types.
package dcache_pkg;

   localparam int DC_ADDR_W     = 32;
   localparam int DC_NUM_LINES  = 16;
   localparam int DC_LINE_BYTES = 32;

   localparam int OFFSET_W = $clog2(DC_LINE_BYTES);
   localparam int INDEX_W  = $clog2(DC_NUM_LINES);
   localparam int TAG_W    = DC_ADDR_W - OFFSET_W - INDEX_W;

   typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, DONE} state_t;

   typedef logic [TAG_W-1:0]           tag_t;
   typedef logic [INDEX_W-1:0]         index_t;
   typedef logic [DC_LINE_BYTES*8-1:0] line_t;

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage for the data cache, one entry per line.
// Latency: combinational read; writes take effect at the next clock edge.
// Backpressure: none, every write is accepted.
// Ports: i_clk, i_rst_n (async, clears valid/dirty only); read port i_rd_idx -> o_rd_*;
//        write port i_we/i_wr_idx with per-word enable i_wen, tag write i_tag_we (also sets valid),
//        dirty update i_dirty_we/i_dirty_val.
module dcache_sram #(
   parameter int NUM_LINES  = 16,
   parameter int LINE_BYTES = 32,
   parameter int TAG_W      = 23
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic [$clog2(NUM_LINES)-1:0] i_rd_idx,
   output logic [TAG_W-1:0]             o_rd_tag,
   output logic                         o_rd_vld,
   output logic                         o_rd_dirty,
   output logic [LINE_BYTES*8-1:0]      o_rd_dat,
   input  logic                         i_we,
   input  logic [$clog2(NUM_LINES)-1:0] i_wr_idx,
   input  logic [LINE_BYTES/4-1:0]      i_wen,
   input  logic [LINE_BYTES*8-1:0]      i_wr_dat,
   input  logic                         i_tag_we,
   input  logic [TAG_W-1:0]             i_wr_tag,
   input  logic                         i_dirty_we,
   input  logic                         i_dirty_val
);

   localparam int WORDS = LINE_BYTES / 4;

   logic [LINE_BYTES*8-1:0] r_data [NUM_LINES];
   logic [TAG_W-1:0]        r_tag  [NUM_LINES];
   logic [NUM_LINES-1:0]    r_vld;
   logic [NUM_LINES-1:0]    r_dirty;

   assign o_rd_tag   = r_tag[i_rd_idx];
   assign o_rd_vld   = r_vld[i_rd_idx];
   assign o_rd_dirty = r_dirty[i_rd_idx];
   assign o_rd_dat   = r_data[i_rd_idx];

   // Only the state bits are reset; stale data/tags are harmless once valid is clear.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_vld   <= '0;
         r_dirty <= '0;
      end else if (i_we) begin
         if (i_tag_we)   r_vld[i_wr_idx]   <= 1'b1;
         if (i_dirty_we) r_dirty[i_wr_idx] <= i_dirty_val;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         for (int w = 0; w < WORDS; w++) begin
            if (i_wen[w]) r_data[i_wr_idx][w*32 +: 32] <= i_wr_dat[w*32 +: 32];
         end
         if (i_tag_we) r_tag[i_wr_idx] <= i_wr_tag;
      end
   end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back write-allocate L1 D-cache controller between the MEM stage and data memory.
// Latency: hits complete in the request cycle; misses take 2 cycles + memory latency (+ write-back latency if dirty).
// Backpressure: cpu_stall_o freezes the pipeline while missing; memory side holds mem_req_o until mem_ack_i.
// Ports: clk_i, rst_i (async active-low); CPU: cpu_read_i, cpu_write_i, cpu_addr_i, cpu_wdata_i, cpu_rdata_o, cpu_stall_o;
//        memory: mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_rdata_i, mem_ack_i.
// Optional: define DCACHE_STATS_EN to add hit_cnt_o / miss_cnt_o counters.
module dcache_ctrl
   import dcache_pkg::*;
#(
   parameter int ADDR_W     = DC_ADDR_W,
   parameter int NUM_LINES  = DC_NUM_LINES,
   parameter int LINE_BYTES = DC_LINE_BYTES
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    cpu_read_i,
   input  logic                    cpu_write_i,
   input  logic [ADDR_W-1:0]       cpu_addr_i,
   input  logic [31:0]             cpu_wdata_i,
   output logic [31:0]             cpu_rdata_o,
   output logic                    cpu_stall_o,
   output logic                    mem_req_o,
   output logic                    mem_we_o,
   output logic [ADDR_W-1:0]       mem_addr_o,
   output logic [LINE_BYTES*8-1:0] mem_wdata_o,
   input  logic [LINE_BYTES*8-1:0] mem_rdata_i,
   input  logic                    mem_ack_i
`ifdef DCACHE_STATS_EN
  ,output logic [31:0]             hit_cnt_o,
   output logic [31:0]             miss_cnt_o
`endif
);

   localparam int OFF_W  = $clog2(LINE_BYTES);
   localparam int IDX_W  = $clog2(NUM_LINES);
   localparam int TG_W   = ADDR_W - OFF_W - IDX_W;
   localparam int WORDS  = LINE_BYTES / 4;
   localparam int WSEL_W = OFF_W - 2;
   localparam int LINE_W = LINE_BYTES * 8;

   state_t              r_state;
   logic [TG_W-1:0]     r_tag;
   logic [IDX_W-1:0]    r_idx;
   logic [WSEL_W-1:0]   r_word;
   logic                r_is_wr;
   logic                r_reacc;   // first IDLE cycle after DONE: the replayed access
   logic                r_mem_req, r_mem_we;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [LINE_W-1:0]   r_mem_wdata;

   logic [TG_W-1:0]     w_tag;
   logic [IDX_W-1:0]    w_idx, w_rd_idx, w_wr_idx;
   logic [WSEL_W-1:0]   w_word;
   logic                w_req, w_idle, w_hit, w_miss, w_unused;
   logic [TG_W-1:0]     w_line_tag;
   logic                w_line_vld, w_line_dirty;
   logic [LINE_W-1:0]   w_line_dat, w_wr_dat;
   logic                w_we, w_tag_we, w_dirty_we, w_dirty_val;
   logic [WORDS-1:0]    w_wen;

   assign w_tag    = cpu_addr_i[ADDR_W-1 -: TG_W];
   assign w_idx    = cpu_addr_i[OFF_W +: IDX_W];
   assign w_word   = cpu_addr_i[2 +: WSEL_W];
   assign w_unused = &{1'b0, cpu_addr_i[1:0]};
   assign w_req    = cpu_read_i | cpu_write_i;
   assign w_idle   = (r_state == IDLE);
   // Outside IDLE the array is addressed by the latched miss index.
   assign w_rd_idx = w_idle ? w_idx : r_idx;
   assign w_hit    = w_line_vld && (w_line_tag == w_tag);
   assign w_miss   = w_idle && w_req && !w_hit;

   assign cpu_stall_o = rst_i && (!w_idle || w_miss);
   assign cpu_rdata_o = (rst_i && w_idle && cpu_read_i && !cpu_write_i && w_hit) ?
                        w_line_dat[w_word*32 +: 32] : 32'h0;
   assign mem_req_o   = r_mem_req;
   assign mem_we_o    = r_mem_we;
   assign mem_addr_o  = r_mem_addr;
   assign mem_wdata_o = r_mem_wdata;

   // Array write port: store hit, refill, or post-refill store merge.
   always_comb begin
      w_we        = 1'b0;
      w_wr_idx    = r_idx;
      w_wen       = '0;
      w_wr_dat    = {WORDS{cpu_wdata_i}};
      w_tag_we    = 1'b0;
      w_dirty_we  = 1'b0;
      w_dirty_val = 1'b0;
      case (r_state)
         IDLE: if (w_req && cpu_write_i && w_hit) begin
            w_we          = 1'b1;
            w_wr_idx      = w_idx;
            w_wen[w_word] = 1'b1;
            w_dirty_we    = 1'b1;
            w_dirty_val   = 1'b1;
         end
         REFILL: if (mem_ack_i) begin
            w_we       = 1'b1;
            w_wen      = '1;
            w_wr_dat   = mem_rdata_i;
            w_tag_we   = 1'b1;
            w_dirty_we = 1'b1;
         end
         DONE: if (r_is_wr) begin
            w_we          = 1'b1;
            w_wen[r_word] = 1'b1;
            w_dirty_we    = 1'b1;
            w_dirty_val   = 1'b1;
         end
         default: ;
      endcase
   end

   dcache_sram #(.NUM_LINES(NUM_LINES), .LINE_BYTES(LINE_BYTES), .TAG_W(TG_W)) u_sram (
      .i_clk(clk_i), .i_rst_n(rst_i),
      .i_rd_idx(w_rd_idx), .o_rd_tag(w_line_tag), .o_rd_vld(w_line_vld),
      .o_rd_dirty(w_line_dirty), .o_rd_dat(w_line_dat),
      .i_we(w_we), .i_wr_idx(w_wr_idx), .i_wen(w_wen), .i_wr_dat(w_wr_dat),
      .i_tag_we(w_tag_we), .i_wr_tag(r_tag),
      .i_dirty_we(w_dirty_we), .i_dirty_val(w_dirty_val)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state     <= IDLE;
         r_tag       <= '0;
         r_idx       <= '0;
         r_word      <= '0;
         r_is_wr     <= 1'b0;
         r_reacc     <= 1'b0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
`ifdef DCACHE_STATS_EN
         hit_cnt_o   <= '0;
         miss_cnt_o  <= '0;
`endif
      end else begin
         r_reacc <= 1'b0;
         case (r_state)
            IDLE: if (w_miss) begin
               r_tag     <= w_tag;
               r_idx     <= w_idx;
               r_word    <= w_word;
               r_is_wr   <= cpu_write_i;
               r_mem_req <= 1'b1;
               if (w_line_vld && w_line_dirty) begin
                  r_state     <= WRITEBACK;
                  r_mem_we    <= 1'b1;
                  r_mem_addr  <= {w_line_tag, w_idx, {OFF_W{1'b0}}};
                  r_mem_wdata <= w_line_dat;
               end else begin
                  r_state    <= REFILL;
                  r_mem_we   <= 1'b0;
                  r_mem_addr <= {w_tag, w_idx, {OFF_W{1'b0}}};
               end
            end
            // Request stays up across the write-back -> refill hand-over; only the address/direction change.
            WRITEBACK: if (mem_ack_i) begin
               r_state    <= REFILL;
               r_mem_we   <= 1'b0;
               r_mem_addr <= {r_tag, r_idx, {OFF_W{1'b0}}};
            end
            REFILL: if (mem_ack_i) begin
               r_state   <= DONE;
               r_mem_req <= 1'b0;
            end
            DONE: begin
               r_state <= IDLE;
               r_reacc <= 1'b1;
            end
            default: r_state <= IDLE;
         endcase
`ifdef DCACHE_STATS_EN
         if (w_miss) miss_cnt_o <= miss_cnt_o + 32'd1;
         if (w_idle && w_req && w_hit && !r_reacc) hit_cnt_o <= hit_cnt_o + 32'd1;
`endif
      end
   end

endmodule
